// File: rtl/ntt_pkg.sv
// Shared types and helpers for the radix-2 NTT butterfly address generator.
package ntt_pkg;

    localparam int ADDR_W  = 10;
    localparam int TW_W    = ADDR_W - 1;
    localparam int LOG_W   = 4;
    localparam int STAGE_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_WAIT,
        ST_FIN
    } state_t;

    // cfg selects N = 8 << cfg, so log2(N) = cfg + 3.
    function automatic logic [LOG_W-1:0] cfg_to_log_n(input logic [2:0] cfg);
        return LOG_W'(cfg) + LOG_W'(3);
    endfunction

    function automatic logic [LOG_W-1:0] log2_pow2(input logic [ADDR_W-1:0] x);
        logic [LOG_W-1:0] r;
        r = '0;
        for (int i = 0; i < ADDR_W; i++) begin
            if (x[i]) r = LOG_W'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/ntt_bfly_lane_addr.sv
// One butterfly's (top, bottom, twiddle) addresses from its linear index k within a stage.
module ntt_bfly_lane_addr #(
    parameter int ADDR_W = ntt_pkg::ADDR_W,
    parameter int TW_W   = ntt_pkg::TW_W,
    parameter int LOG_W  = ntt_pkg::LOG_W
) (
    input  logic [ADDR_W-1:0] i_k,
    input  logic [ADDR_W-1:0] i_h,
    input  logic [LOG_W-1:0]  i_log_h,
    input  logic [LOG_W-1:0]  i_log_n,
    output logic [ADDR_W-1:0] o_top,
    output logic [ADDR_W-1:0] o_bot,
    output logic [TW_W-1:0]   o_tw
);

    logic [ADDR_W-1:0] w_g;
    logic [ADDR_W-1:0] w_j;
    logic [ADDR_W-1:0] w_top;
    logic [LOG_W-1:0]  w_top_sh;
    logic [LOG_W-1:0]  w_tw_sh;

    // k splits into group g (which 2h-wide block) and offset j inside the block.
    assign w_g      = i_k >> i_log_h;
    assign w_j      = i_k & (i_h - ADDR_W'(1));
    assign w_top_sh = i_log_h + LOG_W'(1);
    assign w_top    = (w_g << w_top_sh) | w_j;
    assign w_tw_sh  = i_log_n - LOG_W'(1) - i_log_h;

    assign o_top = w_top;
    assign o_bot = w_top + i_h;
    assign o_tw  = TW_W'(w_j << w_tw_sh);

endmodule

// File: rtl/ntt_bfly_addr_gen.sv
// Radix-2 NTT butterfly address generator: LANES butterflies per beat over valid/ready,
// stepping stages on the configuration block's trigger.
module ntt_bfly_addr_gen #(
    parameter int LANES  = 4,
    parameter int ADDR_W = ntt_pkg::ADDR_W,
    parameter int TW_W   = ntt_pkg::TW_W
) (
    input  logic                    clk,
    input  logic                    i_reset,
    input  logic                    i_start,
    input  logic [2:0]              i_point_configuration,
    input  logic [ADDR_W-1:0]       i_stride,
    input  logic                    i_new_stage_trigger,
    input  logic                    i_ready,
    output logic                    o_valid,
    output logic [LANES*ADDR_W-1:0] o_top_addr,
    output logic [LANES*ADDR_W-1:0] o_bot_addr,
    output logic [LANES*TW_W-1:0]   o_tw_idx,
    output logic                    o_working,
    output logic [3:0]              o_stage,
    output logic                    o_busy,
    output logic                    o_done
);
    import ntt_pkg::*;

    state_t r_state;
    state_t w_state_nxt;

    logic [LOG_W-1:0]  r_log_n;
    logic [LOG_W-1:0]  r_log_h;
    logic [ADDR_W-1:0] r_h;
    logic [ADDR_W-1:0] r_k_base;
    logic [3:0]        r_stage;

    logic [LANES-1:0][ADDR_W-1:0] r_top;
    logic [LANES-1:0][ADDR_W-1:0] r_bot;
    logic [LANES-1:0][TW_W-1:0]   r_tw;

    logic [LANES-1:0][ADDR_W-1:0] w_top;
    logic [LANES-1:0][ADDR_W-1:0] w_bot;
    logic [LANES-1:0][TW_W-1:0]   w_tw;

    logic              w_load;
    logic              w_accept;
    logic              w_last_beat;
    logic [ADDR_W-1:0] w_half_n;
    logic [ADDR_W-1:0] w_k_nxt;
    logic [ADDR_W-1:0] w_h_nxt;
    logic [LOG_W-1:0]  w_log_h_nxt;

    assign w_load      = (r_state == ST_LOAD);
    assign w_accept    = (r_state == ST_RUN) && i_ready;
    assign w_half_n    = ADDR_W'(1) << (r_log_n - LOG_W'(1));
    assign w_last_beat = (r_k_base == w_half_n - ADDR_W'(LANES));

    // Lanes always compute the *next* beat so the output registers can load it on
    // LOAD (first beat, from the fresh stride) or on an accepted beat.
    assign w_k_nxt     = w_load ? '0 : r_k_base + ADDR_W'(LANES);
    assign w_h_nxt     = w_load ? i_stride : r_h;
    assign w_log_h_nxt = w_load ? log2_pow2(i_stride) : r_log_h;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        ntt_bfly_lane_addr #(
            .ADDR_W (ADDR_W),
            .TW_W   (TW_W),
            .LOG_W  (LOG_W)
        ) u_lane (
            .i_k     (w_k_nxt + ADDR_W'(l)),
            .i_h     (w_h_nxt),
            .i_log_h (w_log_h_nxt),
            .i_log_n (r_log_n),
            .o_top   (w_top[l]),
            .o_bot   (w_bot[l]),
            .o_tw    (w_tw[l])
        );
    end

    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        o_valid     = 1'b0;
        o_done      = 1'b0;
        o_busy      = 1'b1;
        unique case (r_state)
            ST_IDLE: begin
                o_busy = 1'b0;
                if (i_start) w_state_nxt = ST_LOAD;
            end
            ST_LOAD: w_state_nxt = ST_RUN;
            ST_RUN: begin
                o_valid = 1'b1;
                if (w_accept && w_last_beat)
                    w_state_nxt = (r_h == ADDR_W'(1)) ? ST_FIN : ST_WAIT;
            end
            ST_WAIT: begin
                if (i_new_stage_trigger) w_state_nxt = ST_LOAD;
            end
            ST_FIN: begin
                o_done      = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            r_log_n  <= '0;
            r_log_h  <= '0;
            r_h      <= '0;
            r_k_base <= '0;
            r_stage  <= '0;
            r_top    <= '0;
            r_bot    <= '0;
            r_tw     <= '0;
        end else begin
            if (r_state == ST_IDLE && i_start) begin
                r_log_n <= cfg_to_log_n(i_point_configuration);
                r_stage <= '0;
            end
            if (r_state == ST_WAIT && i_new_stage_trigger)
                r_stage <= r_stage + 4'd1;
            if (w_load) begin
                r_h      <= i_stride;
                r_log_h  <= w_log_h_nxt;
                r_k_base <= '0;
            end else if (w_accept) begin
                r_k_base <= w_k_nxt;
            end
            // Hold the presented beat until accepted; nothing past the stage end is loaded.
            if (w_load || (w_accept && !w_last_beat)) begin
                r_top <= w_top;
                r_bot <= w_bot;
                r_tw  <= w_tw;
            end
        end
    end

    assign o_top_addr = r_top;
    assign o_bot_addr = r_bot;
    assign o_tw_idx   = r_tw;
    assign o_stage    = r_stage;
    assign o_working  = o_valid & i_ready;

endmodule

// File: tb/tb_ntt_bfly_addr_gen.sv
// Randomized bench for ntt_bfly_addr_gen against a nested-loop butterfly enumeration model.
module tb_ntt_bfly_addr_gen;

    localparam int LANES = 4;
    localparam int AW    = 10;
    localparam int TWW   = 9;

    logic                clk = 1'b0;
    logic                i_reset;
    logic                i_start;
    logic [2:0]          i_point_configuration;
    logic [AW-1:0]       i_stride;
    logic                i_new_stage_trigger;
    logic                i_ready;
    logic                o_valid;
    logic [LANES*AW-1:0] o_top_addr;
    logic [LANES*AW-1:0] o_bot_addr;
    logic [LANES*TWW-1:0] o_tw_idx;
    logic                o_working;
    logic [3:0]          o_stage;
    logic                o_busy;
    logic                o_done;

    int n_chk = 0;
    int n_err = 0;
    int qt[$];
    int qb[$];
    int qw[$];

    always #5 clk = ~clk;

    ntt_bfly_addr_gen dut (
        .clk                   (clk),
        .i_reset               (i_reset),
        .i_start               (i_start),
        .i_point_configuration (i_point_configuration),
        .i_stride              (i_stride),
        .i_new_stage_trigger   (i_new_stage_trigger),
        .i_ready               (i_ready),
        .o_valid               (o_valid),
        .o_top_addr            (o_top_addr),
        .o_bot_addr            (o_bot_addr),
        .o_tw_idx              (o_tw_idx),
        .o_working             (o_working),
        .o_stage               (o_stage),
        .o_busy                (o_busy),
        .o_done                (o_done)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_valid"}, o_valid, 0);
        chk({tag, "_done"}, o_done, 0);
        chk({tag, "_busy"}, o_busy, 0);
        chk({tag, "_stage"}, o_stage, 0);
        chk({tag, "_top"}, o_top_addr, 0);
        chk({tag, "_bot"}, o_bot_addr, 0);
        chk({tag, "_tw"}, o_tw_idx, 0);
        chk({tag, "_working"}, o_working, 0);
    endtask

    // Butterflies of one stage in order: blocks of 2h, j runs inside a block,
    // twiddle exponent j * N/(2h).
    task automatic build_stage(input int n, input int h);
        qt.delete(); qb.delete(); qw.delete();
        for (int b = 0; b < n; b += 2 * h) begin
            for (int j = 0; j < h; j++) begin
                qt.push_back(b + j);
                qb.push_back(b + j + h);
                qw.push_back(j * (n / (2 * h)));
            end
        end
    endtask

    task automatic set_stride(input int n, input int h);
        assert (h > 0 && (h & (h - 1)) == 0 && h <= n / 2) else $error("illegal stride %0d", h);
        i_stride = AW'(h);
    endtask

    // Called at the negedge where a start/trigger pulse was just driven.
    task automatic wait_valid(input string tag);
        int lat;
        lat = 1;
        @(negedge clk);
        i_start = 1'b0;
        i_new_stage_trigger = 1'b0;
        while (!o_valid && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        chk(tag, lat, 2);
    endtask

    task automatic run_job(input int cfg, input bit rnd, input bit noise,
                           input int stop_stage, input bit mid);
        int n, nst, h;
        bit acc;
        n = 8 << cfg;
        nst = cfg + 3;
        i_point_configuration = 3'(cfg);
        set_stride(n, n / 2);
        i_start = 1'b1;
        wait_valid("lat_start");
        for (int s = 0; s < nst; s++) begin
            h = (n / 2) >> s;
            build_stage(n, h);
            while (qt.size() > 0) begin
                chk("valid", o_valid, 1);
                chk("stage", o_stage, s);
                for (int l = 0; l < LANES; l++) begin
                    chk("top", o_top_addr[l*AW +: AW], qt[l]);
                    chk("bot", o_bot_addr[l*AW +: AW], qb[l]);
                    chk("tw", o_tw_idx[l*TWW +: TWW], qw[l]);
                end
                i_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                if (noise) begin
                    i_start = ($urandom_range(0, 3) == 0);
                    i_new_stage_trigger = ($urandom_range(0, 3) == 0);
                    i_stride = AW'(1 << $urandom_range(0, 9));
                end
                #1 chk("working", o_working, i_ready);
                acc = i_ready;
                @(negedge clk);
                i_start = 1'b0;
                i_new_stage_trigger = 1'b0;
                i_stride = AW'(h);
                if (acc) begin
                    repeat (LANES) begin
                        void'(qt.pop_front());
                        void'(qb.pop_front());
                        void'(qw.pop_front());
                    end
                end
                if (mid && s == stop_stage && acc) return;
            end
            chk("valid_end", o_valid, 0);
            chk("busy_end", o_busy, 1);
            if (s == nst - 1) begin
                chk("done", o_done, 1);
                @(negedge clk);
                chk("done_clr", o_done, 0);
                chk("idle_busy", o_busy, 0);
            end else begin
                chk("done_wait", o_done, 0);
                chk("stage_wait", o_stage, s);
                if (s == stop_stage) return;
                repeat ($urandom_range(0, 3)) begin
                    i_start = noise;
                    @(negedge clk);
                    i_start = 1'b0;
                    chk("wait_hold", o_valid, 0);
                    chk("wait_stage", o_stage, s);
                end
                set_stride(n, h / 2);
                i_new_stage_trigger = 1'b1;
                wait_valid("lat_trig");
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1);
    end

    initial begin
        i_reset = 1'b1;
        i_start = 1'b0;
        i_new_stage_trigger = 1'b0;
        i_ready = 1'b0;
        i_point_configuration = 3'd0;
        i_stride = '0;
        repeat (2) @(negedge clk);
        chk_reset("rst");
        i_reset = 1'b0;
        @(negedge clk);
        chk_reset("idle");

        i_new_stage_trigger = 1'b1;
        @(negedge clk);
        i_new_stage_trigger = 1'b0;
        chk("idle_trig_busy", o_busy, 0);
        chk("idle_trig_stage", o_stage, 0);

        run_job(0, 1'b0, 1'b0, -1, 1'b0);
        run_job(7, 1'b0, 1'b0, 0, 1'b0);
        i_reset = 1'b1;
        @(negedge clk);
        chk_reset("rst_wait");
        i_reset = 1'b0;
        @(negedge clk);

        repeat (3) run_job(1, 1'b1, 1'b1, -1, 1'b0);

        run_job(2, 1'b1, 1'b0, 1, 1'b1);
        chk("pre_rst_valid", o_valid, 1);
        #2 i_reset = 1'b1;
        #1 chk_reset("rst_async");
        @(negedge clk);
        chk_reset("rst_edge");
        i_reset = 1'b0;
        i_ready = 1'b0;
        @(negedge clk);
        run_job(2, 1'b1, 1'b1, -1, 1'b0);

        repeat (6) run_job($urandom_range(0, 5), 1'b1, 1'b1, -1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
